// File: rtl/alu_pkg.sv
// Shared integer-ALU definitions: f3 op-codes, sequencer states, sign extension.
// Used by both the immediate and register-register ALUs.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Replicates bit w-1 of v into every higher bit; callers truncate to their width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single shift step: left, logical right or arithmetic right by amt bits.
// Purely combinational, zero latency, no flow control.
module alu_shift_step #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] val,
  input  logic             dir,
  input  logic             arith,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] res
);

  logic signed [WIDTH-1:0] sval;
  logic        [WIDTH-1:0] sra;

  // Kept in its own signed net so the ternary below cannot strip the sign.
  assign sval = val;
  assign sra  = sval >>> amt;

  assign res = dir ? (arith ? sra : (val >> amt)) : (val << amt);

endmodule

// File: rtl/alu_imm_seq.sv
// Immediate ALU: 1-cycle logic/arith, shifts iterate SHIFT_STEP bits per cycle.
// Result held in DONE until out_ready; in_ready only in IDLE (no overlap of accept and handoff).
module alu_imm_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int IMM_W      = 12,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       f3,
  input  logic             f7b,
  input  logic [WIDTH-1:0] a,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             zero,
  output logic             flow,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   rem;
  logic             dir;
  logic             arith;

  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             flow_c;
  logic             carry_c;
  logic             is_shift;
  logic [SHW-1:0]   step_amt;
  logic [SHW-1:0]   rem_next;
  logic [WIDTH-1:0] step_res;

  assign b        = WIDTH'(sext(64'(imm), IMM_W));
  assign shamt    = imm[SHW-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);
  assign flow_c   = (f3 == F3_ADD) && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign carry_c  = (f3 == F3_ADD) && sum[WIDTH];

  always_comb begin
    res = a;
    case (f3)
      F3_ADD:  res = sum[WIDTH-1:0];
      F3_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      F3_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
      F3_XOR:  res = a ^ b;
      F3_OR:   res = a | b;
      F3_AND:  res = a & b;
      default: res = a;  // shifts reaching here have shamt == 0
    endcase
  end

  assign step_amt = (rem < SHW'(SHIFT_STEP)) ? rem : SHW'(SHIFT_STEP);
  assign rem_next = rem - step_amt;

  alu_shift_step #(.WIDTH(WIDTH), .AMT_W(SHW)) u_step (
    .val   (work),
    .dir   (dir),
    .arith (arith),
    .amt   (step_amt),
    .res   (step_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      o         <= '0;
      zero      <= 1'b0;
      flow      <= 1'b0;
      carry     <= 1'b0;
      work      <= '0;
      rem       <= '0;
      dir       <= 1'b0;
      arith     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_shift && shamt != '0) begin
              work  <= a;
              rem   <= shamt;
              dir   <= (f3 == F3_SR);
              arith <= (f3 == F3_SR) && f7b;
              state <= SHIFT;
            end else begin
              o         <= res;
              zero      <= (res == '0);
              flow      <= flow_c;
              carry     <= carry_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= step_res;
          rem  <= rem_next;
          if (rem_next == '0) begin
            o         <= step_res;
            zero      <= (step_res == '0);
            flow      <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
